// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//    Moore-style main control unit for a multicycle RISC-V datapath that
//    executes ld, sd, R-type ALU ops and beq. Each instruction moves
//    through a fixed set of states. Every datapath control is a pure
//    function of the current state. Opcodes the unit does not support are
//    recorded in a sticky "illegal" flag, and the machine goes straight
//    back to FETCH.
//
// Parameters:
//    LD, SD, RTYPE, BEQ  7-bit opcode values for the supported classes
//
// Ports:
//    clock        in   rising-edge clock
//    reset        in   asynchronous active-high reset
//    opcode[6:0]  in   IR[6:0] from the datapath (sampled in DECODE/MEMADR)
//    ALUOp[1:0]   out  ALU operation class (00 add, 01 sub/compare, 10 funct)
//    ALUSrcB[1:0] out  ALU B-mux select (00 B, 01 const 4, 10 ImmGen,
//                      11 PCOffset)
//    MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite,
//    PCWrite, PCWriteCond, ALUSrcA, PCSource
//                 out  single-bit datapath controls
//    state[3:0]   out  current state encoding (debug visibility)
//    illegal      out  sticky flag, set when an unsupported opcode is decoded
//    retired[31:0] out count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
   parameter logic [6:0] LD    = 7'b000_0011,
   parameter logic [6:0] SD    = 7'b010_0011,
   parameter logic [6:0] RTYPE = 7'b011_0011,
   parameter logic [6:0] BEQ   = 7'b110_0011
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  opcode,
   output logic [1:0]  ALUOp,
   output logic [1:0]  ALUSrcB,
   output logic        MemtoReg,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IorD,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        ALUSrcA,
   output logic        PCSource,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] retired
);

   // The nine architected states. The remaining encodings 9-15 are
   // unreachable in normal operation; they are caught by the default arms
   // below so that a corrupted state register recovers to FETCH.
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      REXEC  = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8
   } stateT;

   stateT       stateReg;
   stateT       stateNext;

   logic        isLd;
   logic        isSd;
   logic        isRtype;
   logic        isBeq;
   logic        isSupported;
   logic        decodeIllegal;
   logic        retireNow;
   logic [31:0] retiredCount;

   // Opcode class decode. These signals are only acted on in DECODE and
   // MEMADR, so opcode changes in any other state are harmless.
   always_comb begin
      isLd        = (opcode == LD);
      isSd        = (opcode == SD);
      isRtype     = (opcode == RTYPE);
      isBeq       = (opcode == BEQ);
      isSupported = isLd | isSd | isRtype | isBeq;
   end

   // An instruction completes when the machine leaves one of the four
   // final states. An unsupported opcode is detected as the machine leaves
   // DECODE. Because each of these states lasts exactly one cycle, "being
   // in the state" is the same as "leaving it on the next edge".
   always_comb begin
      decodeIllegal = (stateReg == DECODE) && !isSupported;
      retireNow     = (stateReg == MEMWB) || (stateReg == MEMWR) ||
                      (stateReg == RWB)   || (stateReg == BRANCH);
   end

   // State register. Reset forces FETCH immediately, without waiting for
   // a clock edge, so any partly executed instruction is abandoned.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateReg <= FETCH;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state logic. Only DECODE and MEMADR look at the opcode. MEMADR
   // samples it again: if the opcode has changed to something other than
   // ld/sd by then, the instruction is dropped quietly. It is not flagged
   // as illegal, because the opcode already passed the DECODE check.
   always_comb begin
      stateNext = FETCH;
      case (stateReg)
         FETCH: begin
            stateNext = DECODE;
         end
         DECODE: begin
            if (isLd || isSd) begin
               stateNext = MEMADR;
            end else if (isRtype) begin
               stateNext = REXEC;
            end else if (isBeq) begin
               stateNext = BRANCH;
            end else begin
               stateNext = FETCH;
            end
         end
         MEMADR: begin
            if (isLd) begin
               stateNext = MEMRD;
            end else if (isSd) begin
               stateNext = MEMWR;
            end else begin
               stateNext = FETCH;
            end
         end
         MEMRD: begin
            stateNext = MEMWB;
         end
         MEMWB: begin
            stateNext = FETCH;
         end
         MEMWR: begin
            stateNext = FETCH;
         end
         REXEC: begin
            stateNext = RWB;
         end
         RWB: begin
            stateNext = FETCH;
         end
         BRANCH: begin
            stateNext = FETCH;
         end
         default: begin
            stateNext = FETCH;
         end
      endcase
   end

   // Moore output decode. Every control defaults to 0 and is raised only
   // in the states that need it. While reset is held, all outputs are
   // forced to 0, which also masks the FETCH controls: otherwise the
   // datapath would load the PC and the IR during reset. As a consequence
   // of this table, MemRead/MemWrite and RegWrite/IRWrite are never both
   // high in the same state.
   always_comb begin
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      MemtoReg    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      RegWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      ALUSrcA     = 1'b0;
      PCSource    = 1'b0;
      if (!reset) begin
         case (stateReg)
            FETCH: begin
               MemRead  = 1'b1;
               IRWrite  = 1'b1;
               ALUSrcB  = 2'b01;
               PCWrite  = 1'b1;
            end
            DECODE: begin
               ALUSrcB  = 2'b11;
            end
            MEMADR: begin
               ALUSrcA  = 1'b1;
               ALUSrcB  = 2'b10;
            end
            MEMRD: begin
               MemRead  = 1'b1;
               IorD     = 1'b1;
            end
            MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            REXEC: begin
               ALUSrcA  = 1'b1;
               ALUOp    = 2'b10;
            end
            RWB: begin
               RegWrite = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 1'b1;
            end
            default: begin
               ALUOp = 2'b00;
            end
         endcase
      end
   end

   // Sticky illegal-opcode flag. Once the flag is set, only reset clears
   // it. Later illegal opcodes leave it set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         illegal <= 1'b0;
      end else if (decodeIllegal) begin
         illegal <= 1'b1;
      end
   end

   // Retired-instruction counter. It is updated only on a completing edge
   // and wraps naturally at 32 bits. Illegal and abandoned instructions
   // never reach a completing state, so they are not counted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retiredCount <= 32'd0;
      end else if (retireNow) begin
         retiredCount <= retiredCount + 32'd1;
      end
   end

   // Debug state view and counter output.
   assign state   = stateReg;
   assign retired = retiredCount;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. The stimulus process drives
// opcodes instruction by instruction and queues the expected per-cycle view
// (state, controls, retired, illegal). A monitor pops one entry at each
// falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   localparam logic [6:0] OP_LD    = 7'b000_0011;
   localparam logic [6:0] OP_SD    = 7'b010_0011;
   localparam logic [6:0] OP_RTYPE = 7'b011_0011;
   localparam logic [6:0] OP_BEQ   = 7'b110_0011;
   localparam logic [6:0] OP_BAD   = 7'b111_1111;

   // Control vectors, packed as {ALUOp, ALUSrcB, MemtoReg, MemRead,
   // MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
   // PCSource}.
   localparam logic [13:0] C_NONE   = 14'b00_00_0_0_0_0_0_0_0_0_0_0;
   localparam logic [13:0] C_FETCH  = 14'b00_01_0_1_0_0_0_1_1_0_0_0;
   localparam logic [13:0] C_DECODE = 14'b00_11_0_0_0_0_0_0_0_0_0_0;
   localparam logic [13:0] C_MEMADR = 14'b00_10_0_0_0_0_0_0_0_0_1_0;
   localparam logic [13:0] C_MEMRD  = 14'b00_00_0_1_0_1_0_0_0_0_0_0;
   localparam logic [13:0] C_MEMWB  = 14'b00_00_1_0_0_0_1_0_0_0_0_0;
   localparam logic [13:0] C_MEMWR  = 14'b00_00_0_0_1_1_0_0_0_0_0_0;
   localparam logic [13:0] C_REXEC  = 14'b10_00_0_0_0_0_0_0_0_0_1_0;
   localparam logic [13:0] C_RWB    = 14'b00_00_0_0_0_0_1_0_0_0_0_0;
   localparam logic [13:0] C_BRANCH = 14'b01_00_0_0_0_0_0_0_0_1_1_1;

   typedef struct packed {
      logic [3:0]  st;
      logic [13:0] ctl;
      logic [31:0] ret;
      logic        ill;
   } expRec;

   logic        clock;
   logic        reset;
   logic [6:0]  opcode;
   logic [1:0]  ALUOp;
   logic [1:0]  ALUSrcB;
   logic        MemtoReg;
   logic        MemRead;
   logic        MemWrite;
   logic        IorD;
   logic        RegWrite;
   logic        IRWrite;
   logic        PCWrite;
   logic        PCWriteCond;
   logic        ALUSrcA;
   logic        PCSource;
   logic [3:0]  state;
   logic        illegal;
   logic [31:0] retired;
   logic [13:0] actCtl;

   expRec       sbQ[$];
   int          checks;
   int          failures;
   int          sampleIdx;
   logic [31:0] expRetired;
   logic        expIllegal;

   multicycle_control dut (
      .clock       (clock),
      .reset       (reset),
      .opcode      (opcode),
      .ALUOp       (ALUOp),
      .ALUSrcB     (ALUSrcB),
      .MemtoReg    (MemtoReg),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IorD        (IorD),
      .RegWrite    (RegWrite),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .ALUSrcA     (ALUSrcA),
      .PCSource    (PCSource),
      .state       (state),
      .illegal     (illegal),
      .retired     (retired)
   );

   assign actCtl = {ALUOp, ALUSrcB, MemtoReg, MemRead, MemWrite, IorD,
                    RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, PCSource};

   // 10 ns clock: rising edges at 5, 15, 25, ... and falling edges at 10, 20, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare the DUT outputs with one expected record, one field at a time.
   task automatic checkOutput(input string tag, input expRec e);
      checks++;
      if (state !== e.st) begin
         failures++;
         $display("[TB] FAIL %s state: got %0d expected %0d", tag, state, e.st);
      end
      checks++;
      if (actCtl !== e.ctl) begin
         failures++;
         $display("[TB] FAIL %s ctrl: got %b expected %b", tag, actCtl, e.ctl);
      end
      checks++;
      if (retired !== e.ret) begin
         failures++;
         $display("[TB] FAIL %s retired: got %0h expected %0h", tag, retired, e.ret);
      end
      checks++;
      if (illegal !== e.ill) begin
         failures++;
         $display("[TB] FAIL %s illegal: got %0b expected %0b", tag, illegal, e.ill);
      end
   endtask

   // Monitor: at each falling edge, take the oldest expectation (if any)
   // and compare it. The exclusivity check on memory and register writes
   // is applied to every sampled cycle.
   always @(negedge clock) begin
      if (sbQ.size() > 0) begin
         expRec e;
         string tag;
         e = sbQ.pop_front();
         tag = $sformatf("cyc%0d", sampleIdx);
         sampleIdx++;
         checkOutput(tag, e);
         checks++;
         if ((MemRead && MemWrite) || (RegWrite && IRWrite)) begin
            failures++;
            $display("[TB] FAIL %s exclusive: got ctrl %b expected no MemRead&MemWrite or RegWrite&IRWrite",
                     tag, actCtl);
         end
      end
   end

   function automatic expRec mk(input logic [3:0] st, input logic [13:0] ctl);
      expRec r;
      r.st  = st;
      r.ctl = ctl;
      r.ret = expRetired;
      r.ill = expIllegal;
      return r;
   endfunction

   // Run one instruction. "op" is driven in DECODE, "adrOp" in MEMADR, and
   // either "op" or random noise in every other cycle. Must be called just
   // after a rising edge (or just after reset release), while the DUT is
   // in FETCH.
   task automatic applyStimulus(input logic [6:0] op, input logic [6:0] adrOp,
                                input bit noise);
      expRec seq[$];
      bit    retires;
      bit    flagsIllegal;
      retires      = 1'b0;
      flagsIllegal = 1'b0;
      seq.push_back(mk(4'd0, C_FETCH));
      seq.push_back(mk(4'd1, C_DECODE));
      if (op == OP_LD || op == OP_SD) begin
         seq.push_back(mk(4'd2, C_MEMADR));
         if (adrOp == OP_LD) begin
            seq.push_back(mk(4'd3, C_MEMRD));
            seq.push_back(mk(4'd4, C_MEMWB));
            retires = 1'b1;
         end else if (adrOp == OP_SD) begin
            seq.push_back(mk(4'd5, C_MEMWR));
            retires = 1'b1;
         end
      end else if (op == OP_RTYPE) begin
         seq.push_back(mk(4'd6, C_REXEC));
         seq.push_back(mk(4'd7, C_RWB));
         retires = 1'b1;
      end else if (op == OP_BEQ) begin
         seq.push_back(mk(4'd8, C_BRANCH));
         retires = 1'b1;
      end else begin
         flagsIllegal = 1'b1;
      end
      foreach (seq[i]) sbQ.push_back(seq[i]);
      for (int i = 0; i < seq.size(); i++) begin
         if (i == 1) begin
            opcode = op;
         end else if (i == 2) begin
            opcode = adrOp;
         end else begin
            opcode = noise ? 7'($urandom_range(0, 127)) : op;
         end
         @(posedge clock);
         #1;
      end
      if (retires) expRetired = expRetired + 32'd1;
      if (flagsIllegal) expIllegal = 1'b1;
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      expRec e;
      checks     = 0;
      failures   = 0;
      sampleIdx  = 0;
      expRetired = 32'd0;
      expIllegal = 1'b0;
      reset      = 1'b1;
      opcode     = OP_LD;

      // Reset is asserted from time zero: all controls must be 0, even
      // though the state is FETCH.
      #2;
      e = '{st: 4'd0, ctl: C_NONE, ret: 32'd0, ill: 1'b0};
      checkOutput("reset", e);

      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] ld with noise outside DECODE/MEMADR");
      applyStimulus(OP_LD, OP_LD, 1'b1);
      $display("[TB] sd");
      applyStimulus(OP_SD, OP_SD, 1'b1);
      $display("[TB] beq then rtype");
      applyStimulus(OP_BEQ, OP_BEQ, 1'b0);
      applyStimulus(OP_RTYPE, OP_RTYPE, 1'b1);
      $display("[TB] ld whose opcode changes to rtype in MEMADR");
      applyStimulus(OP_LD, OP_RTYPE, 1'b0);
      $display("[TB] illegal opcode, ld, second illegal opcode");
      applyStimulus(OP_BAD, OP_BAD, 1'b0);
      applyStimulus(OP_LD, OP_LD, 1'b0);
      applyStimulus(7'b000_0000, 7'b000_0000, 1'b0);
      applyStimulus(OP_SD, OP_SD, 1'b0);

      // Asynchronous reset in the middle of MEMRD.
      $display("[TB] reset mid-MEMRD");
      sbQ.push_back(mk(4'd0, C_FETCH));
      sbQ.push_back(mk(4'd1, C_DECODE));
      sbQ.push_back(mk(4'd2, C_MEMADR));
      sbQ.push_back(mk(4'd3, C_MEMRD));
      opcode = OP_LD;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      expRetired = 32'd0;
      expIllegal = 1'b0;
      e = '{st: 4'd0, ctl: C_NONE, ret: 32'd0, ill: 1'b0};
      checkOutput("async_reset", e);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Preload the counter to its maximum, then retire one R-type.
      $display("[TB] retired wrap");
      force dut.retiredCount = 32'hFFFF_FFFF;
      #1;
      release dut.retiredCount;
      expRetired = 32'hFFFF_FFFF;
      applyStimulus(OP_RTYPE, OP_RTYPE, 1'b0);
      applyStimulus(OP_BEQ, OP_BEQ, 1'b0);

      for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(negedge clock);
      checks++;
      if (sbQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter LD, default 7'b000_0011, meaning load-doubleword opcode.
REQ-002 SHALL have parameter SD, default 7'b010_0011, meaning store-doubleword opcode.
REQ-003 SHALL have parameter RTYPE, default 7'b011_0011, meaning register-register ALU opcode.
REQ-004 SHALL have parameter BEQ, default 7'b110_0011, meaning branch-if-equal opcode.
REQ-005 SHALL have port: clock  input  1  rising-edge clock.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: opcode  input  7  IR[6:0] from datapath.
REQ-008 SHALL have ports: ALUOp, ALUSrcB  output  2 each  ALU class and ALU B-mux select (00 B, 01 const 4, 10 ImmGen, 11 PCOffset).
REQ-009 SHALL have ports: MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, PCSource  output  1 each  datapath controls.
REQ-010 SHALL have port: state  output  4  current FSM state encoding (debug).
REQ-011 SHALL have port: illegal  output  1  sticky flag, unsupported opcode decoded.
REQ-012 SHALL have port: retired  output  32  count of completed instructions.

Function
REQ-013 SHALL be a Moore FSM: every control output a pure function of the state register; unlisted controls 0 in every state.
REQ-014 SHALL implement states/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8; encodings 9-15 SHALL transition to FETCH, all controls 0.
REQ-015 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=0; next DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut); next MEMADR if opcode LD or SD, REXEC if RTYPE, BRANCH if BEQ, else FETCH with illegal set.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if opcode==LD, MEMWR if opcode==SD, else FETCH (no illegal set).
REQ-018 MEMRD: MemRead=1, IorD=1; next MEMWB.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1; next FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; next FETCH.
REQ-021 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RWB.
REQ-022 RWB: RegWrite=1, MemtoReg=0; next FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1; next FETCH.
REQ-024 Cycle counts per instruction SHALL be: LD 5, SD 4, RTYPE 4, BEQ 3, illegal 2.
REQ-025 opcode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-026 retired SHALL increment by 1 on each clock edge leaving MEMWB, MEMWR, RWB or BRANCH; SHALL wrap 32'hFFFF_FFFF -> 0; illegal instructions SHALL NOT count.
REQ-027 illegal SHALL go to 1 on the edge leaving DECODE with an unsupported opcode and hold until reset; further illegal opcodes SHALL leave it 1.
REQ-028 At most one of MemRead/MemWrite, and at most one of RegWrite/IRWrite, SHALL be 1 in any cycle.

Reset
REQ-029 reset=1 SHALL immediately (no clock) force state=FETCH, illegal=0, retired=0.
REQ-030 While reset=1 all control outputs SHALL be 0, including FETCH controls; outputs SHALL follow REQ-015 from the first cycle after release.
REQ-031 reset asserted mid-instruction (any state) SHALL abandon it without incrementing retired; first post-release edge SHALL perform FETCH.

Verification
REQ-032 Release reset, opcode=LD held: state 0,1,2,3,4,0; RegWrite=MemtoReg=1 only in state 4; retired 0->1 after 5 edges.
REQ-033 opcode=SD: state 0,1,2,5,0; MemWrite=IorD=1 in state 5 only; RegWrite never 1; retired=1.
REQ-034 opcode=BEQ then RTYPE: BRANCH shows PCWriteCond=1, PCSource=1, ALUOp=01; REXEC ALUOp=10, RWB RegWrite=1, MemtoReg=0; retired=2 after 7 edges.
REQ-035 opcode=7'b111_1111: state 0,1,0; illegal=1 from edge 2 and stays 1 through subsequent LD; retired unchanged by illegal.
REQ-036 Assert reset asynchronously mid-MEMRD (between edges): state=0, all controls 0, retired=0 before next edge; preload retired=32'hFFFF_FFFF via forced sequence, complete one RTYPE -> retired=0.
